hazard_interlock: RTL and testbench

HAZARD_INTERLOCK -- requirements
Module: hazard_interlock

---
 rtl/hazard_interlock.sv | 113 +++++++++++
 tb/tb_hazard_interlock.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_interlock.sv
// Pipeline interlock: load-use and multiply/divide busy stalls, memory-wait freeze,
// multiply/divide busy counter and a saturating stall-cycle counter.
module hazard_interlock #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  op_id,
    input  logic [5:0]  func_id,
    input  logic [4:0]  Rs_id,
    input  logic [4:0]  Rt_id,
    input  logic [5:0]  op_ex,
    input  logic [4:0]  Rw_ex,
    input  logic        mem_wait,
    output logic        pc_wr_en,
    output logic        ifid_wr_en,
    output logic        idex_flush,
    output logic        pipe_wr_en,
    output logic        md_busy,
    output logic [5:0]  md_cnt,
    output logic [15:0] stall_cycles
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT);

    logic [5:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    logic uses_rs, uses_rt, ld_hz;
    logic is_rtype, mul_op, div_op, md_op, md_rd, md_hz;

    // Operand usage decode for the ID instruction
    always_comb begin
        uses_rs = !(op_id == OP_J || op_id == OP_JAL || op_id == OP_LUI);
        uses_rt = (op_id == OP_RTYPE) || (op_id == OP_BEQ) ||
                  (op_id == OP_BNE)   || (op_id == OP_SW);
    end

    // Load-use: the lw result is only forwardable from MEM, so the consumer waits one cycle
    always_comb begin
        ld_hz = (op_ex == OP_LW) && (Rw_ex != 5'd0) &&
                ((uses_rs && (Rs_id == Rw_ex)) || (uses_rt && (Rt_id == Rw_ex)));
    end

    always_comb begin
        is_rtype = (op_id == OP_RTYPE);
        mul_op   = is_rtype && (func_id == 6'b011000 || func_id == 6'b011001);
        div_op   = is_rtype && (func_id == 6'b011010 || func_id == 6'b011011);
        md_op    = mul_op || div_op;
        md_rd    = is_rtype && (func_id[5:2] == 4'b0100);
        md_busy  = (md_cnt_q != 6'd0);
        md_hz    = md_busy && (md_op || md_rd);
    end

    // Stall/flush decision, highest priority first
    always_comb begin
        pc_wr_en   = 1'b1;
        ifid_wr_en = 1'b1;
        pipe_wr_en = 1'b1;
        idex_flush = 1'b0;
        if (mem_wait) begin
            pc_wr_en   = 1'b0;
            ifid_wr_en = 1'b0;
            pipe_wr_en = 1'b0;
        end else if (ld_hz || md_hz) begin
            pc_wr_en   = 1'b0;
            ifid_wr_en = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // An accepted issue can only happen with md_cnt_q==0, since a busy unit stalls md_op
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_op && pc_wr_en) begin
            md_cnt_d = mul_op ? MUL_LOAD : DIV_LOAD;
        end else if (md_cnt_q != 6'd0) begin
            md_cnt_d = md_cnt_q - 6'd1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_wr_en && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q       <= 6'd0;
            stall_cycles_q <= 16'd0;
        end else begin
            md_cnt_q       <= md_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign md_cnt       = md_cnt_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_interlock.sv
// Bench for hazard_interlock: directed scenarios plus random instruction mix,
// all checked against a rule-level reference model.
module tb_hazard_interlock;

    logic        clk, rst_n;
    logic [5:0]  op_id, func_id, op_ex;
    logic [4:0]  Rs_id, Rt_id, Rw_ex;
    logic        mem_wait;
    logic        pc_wr_en, ifid_wr_en, idex_flush, pipe_wr_en, md_busy;
    logic [5:0]  md_cnt;
    logic [15:0] stall_cycles;

    hazard_interlock #(.MUL_LAT(5), .DIV_LAT(33)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_id(op_id), .func_id(func_id), .Rs_id(Rs_id), .Rt_id(Rt_id),
        .op_ex(op_ex), .Rw_ex(Rw_ex), .mem_wait(mem_wait),
        .pc_wr_en(pc_wr_en), .ifid_wr_en(ifid_wr_en), .idex_flush(idex_flush),
        .pipe_wr_en(pipe_wr_en), .md_busy(md_busy), .md_cnt(md_cnt),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_cnt = 0;
    int m_stalls = 0;
    logic e_pc, e_ifid, e_flush, e_pipe;
    int e_load;

    logic [5:0] op_pool [9]    = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd15, 6'd35, 6'd43, 6'd8};
    logic [5:0] func_pool [10] = '{6'd24, 6'd25, 6'd26, 6'd27, 6'd16, 6'd17, 6'd18, 6'd19, 6'd32, 6'd33};
    logic [5:0] opex_pool [4]  = '{6'd35, 6'd35, 6'd0, 6'd43};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs from the instruction-level rules
    task automatic compute_exp();
        bit reads_rs, reads_rt, load_use, is_mul, is_div, is_hilo, md_stall;
        reads_rs = !(op_id inside {6'd2, 6'd3, 6'd15});
        reads_rt = op_id inside {6'd0, 6'd4, 6'd5, 6'd43};
        load_use = (op_ex == 6'd35) && (Rw_ex != 0) &&
                   ((reads_rs && Rs_id == Rw_ex) || (reads_rt && Rt_id == Rw_ex));
        is_mul  = (op_id == 0) && (func_id inside {6'd24, 6'd25});
        is_div  = (op_id == 0) && (func_id inside {6'd26, 6'd27});
        is_hilo = (op_id == 0) && (func_id >= 6'd16) && (func_id <= 6'd19);
        md_stall = (m_cnt > 0) && (is_mul || is_div || is_hilo);
        e_pc    = !mem_wait && !load_use && !md_stall;
        e_ifid  = e_pc;
        e_pipe  = !mem_wait;
        e_flush = !mem_wait && (load_use || md_stall);
        e_load  = !e_pc ? 0 : is_mul ? 5 : is_div ? 33 : 0;
    endtask

    task automatic model_tick();
        if (e_load != 0) m_cnt = e_load;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
        if (!e_pc && m_stalls < 65535) m_stalls = m_stalls + 1;
    endtask

    // One clock: check outputs at the negedge, advance model at the posedge
    task automatic cycle();
        @(negedge clk);
        compute_exp();
        chk("pc_wr_en",     16'(pc_wr_en),     16'(e_pc));
        chk("ifid_wr_en",   16'(ifid_wr_en),   16'(e_ifid));
        chk("idex_flush",   16'(idex_flush),   16'(e_flush));
        chk("pipe_wr_en",   16'(pipe_wr_en),   16'(e_pipe));
        chk("md_cnt",       16'(md_cnt),       16'(m_cnt));
        chk("md_busy",      16'(md_busy),      16'(m_cnt != 0));
        chk("stall_cycles", stall_cycles,      16'(m_stalls));
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic nop();
        op_id = 6'd0; func_id = 6'd32; Rs_id = 5'd0; Rt_id = 5'd0;
        op_ex = 6'd0; Rw_ex = 5'd0; mem_wait = 1'b0;
    endtask

    task automatic rtype(input logic [5:0] f);
        op_id = 6'd0; func_id = f; Rs_id = 5'd1; Rt_id = 5'd2;
        op_ex = 6'd0; Rw_ex = 5'd0; mem_wait = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        #2;
        chk("rst_md_cnt",  16'(md_cnt), 16'd0);
        chk("rst_md_busy", 16'(md_busy), 16'd0);
        chk("rst_stalls",  stall_cycles, 16'd0);
        chk("rst_pc",      16'(pc_wr_en), 16'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        cycle();

        // Load-use on rs, then the bubble in EX lets it through
        op_id = 6'd0; func_id = 6'd32; Rs_id = 5'd8; Rt_id = 5'd3;
        op_ex = 6'd35; Rw_ex = 5'd8;
        #1;
        chk("ld_rs_pc",    16'(pc_wr_en), 16'd0);
        chk("ld_rs_flush", 16'(idex_flush), 16'd1);
        cycle();
        op_ex = 6'd0; #1;
        chk("ld_after_bubble_pc", 16'(pc_wr_en), 16'd1);
        cycle();
        op_ex = 6'd35; Rw_ex = 5'd0; Rs_id = 5'd0; #1;
        chk("ld_r0_pc", 16'(pc_wr_en), 16'd1);
        cycle();

        // beq reads rt; lui reads neither
        op_id = 6'd4; Rs_id = 5'd1; Rt_id = 5'd5; op_ex = 6'd35; Rw_ex = 5'd5; #1;
        chk("beq_rt_pc", 16'(pc_wr_en), 16'd0);
        cycle();
        op_id = 6'd15; Rs_id = 5'd5; Rt_id = 5'd5; #1;
        chk("lui_pc", 16'(pc_wr_en), 16'd1);
        cycle();

        // mult then mflo: five stalls, proceeds at zero
        rtype(6'd24);
        cycle();
        chk("mult_load", 16'(md_cnt), 16'd5);
        rtype(6'd18);
        for (int k = 5; k >= 1; k--) begin
            chk("mflo_cnt", 16'(md_cnt), 16'(k));
            chk("mflo_stall", 16'(pc_wr_en), 16'd0);
            cycle();
        end
        chk("mflo_go_cnt", 16'(md_cnt), 16'd0);
        chk("mflo_go_pc", 16'(pc_wr_en), 16'd1);
        cycle();

        // div then div: 33 stalls, second accepted reloads 33
        rtype(6'd26);
        cycle();
        for (int k = 0; k < 33; k++) cycle();
        chk("div2_cnt0", 16'(md_cnt), 16'd0);
        chk("div2_pc", 16'(pc_wr_en), 16'd1);
        cycle();
        chk("div2_load", 16'(md_cnt), 16'd33);

        // mem_wait dominates a load-use hazard; counter keeps draining
        op_id = 6'd0; func_id = 6'd32; Rs_id = 5'd9; Rt_id = 5'd1;
        op_ex = 6'd35; Rw_ex = 5'd9; mem_wait = 1'b1; #1;
        chk("mw_pc",    16'(pc_wr_en), 16'd0);
        chk("mw_pipe",  16'(pipe_wr_en), 16'd0);
        chk("mw_flush", 16'(idex_flush), 16'd0);
        cycle();
        chk("mw_dec", 16'(md_cnt), 16'd32);
        cycle();

        // Asynchronous reset mid-divide at md_cnt=20
        nop();
        while (m_cnt > 20) cycle();
        chk("pre_rst_cnt", 16'(md_cnt), 16'd20);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cnt",    16'(md_cnt), 16'd0);
        chk("async_rst_stalls", stall_cycles, 16'd0);
        m_cnt = 0; m_stalls = 0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        cycle();

        // Random instruction mix
        for (int n = 0; n < 2000; n++) begin
            op_id    = op_pool[$urandom_range(0, 8)];
            func_id  = func_pool[$urandom_range(0, 9)];
            Rs_id    = 5'($urandom_range(0, 3));
            Rt_id    = 5'($urandom_range(0, 3));
            op_ex    = opex_pool[$urandom_range(0, 3)];
            Rw_ex    = 5'($urandom_range(0, 3));
            mem_wait = ($urandom_range(0, 9) == 0);
            cycle();
        end

        // Saturate stall_cycles with a long memory wait
        nop(); mem_wait = 1'b1;
        cycle();
        for (int n = 0; n < 70000 && m_stalls < 65535; n++) begin
            @(posedge clk);
            compute_exp();
            model_tick();
        end
        #1;
        chk("sat_ffff", stall_cycles, 16'hFFFF);
        cycle();
        cycle();
        chk("sat_hold", stall_cycles, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
